// File: rtl/d_latch_reset_bh_if.sv
// Bundles the latch's data and control nets so a driver and the latch can be
// wired up as a unit; the latch itself keeps its legacy (q, d, en, reset) port list.
interface d_latch_reset_bh_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (
        output en,
        output reset,
        output d,
        input  q
    );

    modport slave (
        input  en,
        input  reset,
        input  d,
        output q
    );
endinterface

// File: rtl/d_latch_reset_bh.sv
// Level-sensitive D latch with asynchronous active-low clear to RESET_VALUE.
// The port order (q, d, en, reset) is kept so that positional instantiations still connect correctly.
module d_latch_reset_bh #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             reset
);

    // Reset dominates the gate; with en low and reset high q simply keeps its value.
    always_latch begin
        if (!reset) begin
            q = RESET_VALUE;
        end else if (en) begin
            q = d;
        end
    end

endmodule

// File: tb/tb_d_latch_reset_bh.sv
// Scoreboard bench: directed and random steps drive two latch instances (1-bit default, 8-bit A5),
// a reference model pushes expectations, and a monitor compares after each step.
module tb_d_latch_reset_bh;

    localparam logic [7:0] RV8 = 8'hA5;

    d_latch_reset_bh_if #(.WIDTH(1)) b1 ();
    d_latch_reset_bh_if #(.WIDTH(8)) b8 ();

    d_latch_reset_bh dut1 (
        .q     (b1.q),
        .d     (b1.d),
        .en    (b1.en),
        .reset (b1.reset)
    );

    d_latch_reset_bh #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
        .q     (b8.q),
        .d     (b8.d),
        .en    (b8.en),
        .reset (b8.reset)
    );

    typedef struct {
        string      tag;
        bit         wide;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t  sb[$];
    event       sample_ev;
    int         checks = 0;
    int         errors = 0;

    // Reference state: what each output should be holding right now.
    logic       gate_val1;
    logic [7:0] gate_val8;
    bit         model_valid = 0;

    // One step: change inputs (en before d, so a simultaneous en fall keeps the old data),
    // derive the expected outputs from the latch rules, then let the monitor sample.
    task automatic step(input string tag, input bit r, input bit e,
                        input logic dv1, input logic [7:0] dv8);
        b1.reset = r;  b8.reset = r;
        b1.en    = e;  b8.en    = e;
        b1.d     = dv1; b8.d    = dv8;
        if (!r) begin
            gate_val1 = 1'b0;
            gate_val8 = RV8;
            model_valid = 1;
        end else if (e) begin
            gate_val1 = dv1;
            gate_val8 = dv8;
            model_valid = 1;
        end
        if (model_valid) begin
            sb.push_back('{tag, 1'b0, {7'b0, gate_val1}});
            sb.push_back('{tag, 1'b1, gate_val8});
        end
        #1;
        -> sample_ev;
        #4;
    endtask

    // Monitor: the latch output is valid one time unit after each input change.
    initial begin
        sb_entry_t  ent;
        logic [7:0] got;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                ent = sb.pop_front();
                got = ent.wide ? b8.q : {7'b0, b1.q};
                checks++;
                if (got !== ent.exp) begin
                    errors++;
                    $display("FAIL %s w%0d q=%h expected %h", ent.tag, ent.wide ? 8 : 1, got, ent.exp);
                end else begin
                    $display("ok   %s w%0d q=%h", ent.tag, ent.wide ? 8 : 1, got);
                end
            end
        end
    end

    initial begin
        logic [7:0] rd;
        b1.en = 0; b1.reset = 1; b1.d = 0;
        b8.en = 0; b8.reset = 1; b8.d = 0;
        #5;

        // Reset held: data and gate ignored.
        step("rst_en0_d0", 0, 0, 1'b0, 8'h00);
        step("rst_en0_d1", 0, 0, 1'b1, 8'hFF);
        step("rst_en1_d0", 0, 1, 1'b0, 8'h00);
        step("rst_en1_d1", 0, 1, 1'b1, 8'h3C);
        // Deassert with en low: keeps reset value, then holds against d.
        step("rel_en0",    1, 0, 1'b1, 8'h77);
        step("hold_d0",    1, 0, 1'b0, 8'h00);
        step("hold_d1",    1, 0, 1'b1, 8'hFF);
        // Transparency.
        step("trans_d0",   1, 1, 1'b0, 8'h00);
        step("trans_d1",   1, 1, 1'b1, 8'h3C);
        // Close the gate, then move d: capture holds.
        step("close",      1, 0, 1'b1, 8'h3C);
        step("close_d0",   1, 0, 1'b0, 8'hFF);
        // Reset with gate closed: immediate clear.
        step("rst_closed", 0, 0, 1'b0, 8'hFF);
        // Deassert with en high: takes current d at once.
        step("rel_en1",    1, 1, 1'b1, 8'h5A);
        // Gate falls in the same step as d changes: old d wins.
        step("fall_dchg",  1, 0, 1'b0, 8'hC3);
        step("fall_hold",  1, 0, 1'b1, 8'h0F);

        for (int i = 0; i < 150; i++) begin
            rd = 8'($urandom);
            step($sformatf("rand%0d", i), ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), rd);
        end

        #5;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
